// File: rtl/vga_pkg.sv
// Shared game constants: 4-bit key codes, PS/2 scan codes, receiver state type and scan-code mapping.
package vga_pkg;

  localparam logic [3:0] key_relesed = 4'd0;
  localparam logic [3:0] key_A       = 4'd1;
  localparam logic [3:0] key_S       = 4'd2;
  localparam logic [3:0] key_W       = 4'd3;
  localparam logic [3:0] key_D       = 4'd4;
  localparam logic [3:0] key_1       = 4'd5;
  localparam logic [3:0] key_2       = 4'd6;
  localparam logic [3:0] key_3       = 4'd7;
  localparam logic [3:0] key_4       = 4'd8;
  localparam logic [3:0] key_esc     = 4'd9;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} ps2_rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } key_map_t;

  function automatic key_map_t map_scan(input logic [7:0] sc);
    key_map_t m;
    m = '{hit: 1'b1, code: key_relesed};
    case (sc)
      SC_A:    m.code = key_A;
      SC_S:    m.code = key_S;
      SC_W:    m.code = key_W;
      SC_D:    m.code = key_D;
      SC_1:    m.code = key_1;
      SC_2:    m.code = key_2;
      SC_3:    m.code = key_3;
      SC_4:    m.code = key_4;
      SC_ESC:  m.code = key_esc;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM with odd-parity
// check and a stall timeout that discards partial frames.
module ps2_rx
  import vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_rx_state_t state, next_state;
  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             parity;
  logic [CNT_W-1:0] idle_cnt;
  logic             fall, bit_in, timeout;

  // Two synchronizer stages per pin; clk_sync[2] is the extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state != RX_IDLE) && !fall && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rx_byte = shift;

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = RX_IDLE;
    end else if (fall) begin
      unique case (state)
        RX_IDLE:   if (!bit_in) next_state = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) next_state = RX_PARITY;
        RX_PARITY: next_state = RX_STOP;
        RX_STOP:   next_state = RX_IDLE;
        default:   next_state = RX_IDLE;
      endcase
    end
  end

  // Strobe and error are Mealy outputs so the top can register them with one cycle of latency.
  always_comb begin
    rx_strobe = 1'b0;
    rx_err    = timeout;
    if (fall && state == RX_IDLE && bit_in) rx_err = 1'b1;
    if (fall && state == RX_STOP) begin
      if (bit_in && (^{shift, parity})) rx_strobe = 1'b1;
      else                              rx_err    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      parity   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= (fall || timeout || state == RX_IDLE) ? '0 : idle_cnt + 1'b1;
      if (timeout) begin
        shift   <= 8'h00;
        bit_cnt <= 3'd0;
      end else if (fall) begin
        case (state)
          RX_IDLE:   bit_cnt <= 3'd0;
          RX_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: parity <= bit_in;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Translates PS/2 scan-code bytes into held game key codes with an event strobe.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make codes.
module ps2_key_decoder
  import vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_strobe, rx_err;
  logic       ext_pending, brk_pending;
  logic       make_ok;
  key_map_t   map;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (rx_err)
  );

  assign map = map_scan(rx_byte);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign make_ok = (map.code != key_code);
`else
  assign make_ok = 1'b1;
`endif

  // Prefix bytes only arm flags; the next scan code consumes and clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code    <= key_relesed;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      if (rx_strobe) begin
        if (rx_byte == SC_EXT) begin
          ext_pending <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk_pending <= 1'b1;
        end else begin
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
          if (map.hit && !ext_pending) begin
            if (brk_pending) begin
              if (map.code == key_code) begin
                key_code  <= key_relesed;
                key_valid <= 1'b1;
              end
            end else if (make_ok) begin
              key_code  <= map.code;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed and random PS/2 frames against a key-state model.
// Honours PS2_TYPEMATIC_FILTER_EN in the model when the build defines it.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 100;
  localparam int HALF    = 10;

  typedef struct {
    logic       is_err;
    logic [3:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key_code;
  logic       key_valid, frame_err;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;
  logic [3:0] ref_key = 4'd0;
  bit         ref_ext = 0;
  bit         ref_brk = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Game key table: returns 0 for scan codes the game does not use.
  function automatic logic [3:0] lookup(input logic [7:0] sc);
    case (sc)
      8'h1C: return 4'd1;
      8'h1B: return 4'd2;
      8'h1D: return 4'd3;
      8'h23: return 4'd4;
      8'h16: return 4'd5;
      8'h1E: return 4'd6;
      8'h26: return 4'd7;
      8'h25: return 4'd8;
      8'h76: return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push_event(input logic is_err, input logic [3:0] code);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] k;
    if (b == 8'hE0) ref_ext = 1;
    else if (b == 8'hF0) ref_brk = 1;
    else begin
      k = lookup(b);
      if (k != 4'd0 && !ref_ext) begin
        if (ref_brk) begin
          if (k == ref_key) begin
            ref_key = 4'd0;
            push_event(1'b0, ref_key);
          end
        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (k != ref_key) begin
            ref_key = k;
            push_event(1'b0, k);
          end
`else
          ref_key = k;
          push_event(1'b0, k);
`endif
        end
      end
      ref_ext = 0;
      ref_brk = 0;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    if (bad_par || bad_stop) push_event(1'b1, 4'd0);
    else model_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_clks(3 * HALF);
  endtask

  task automatic check_eq(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (key_valid || frame_err)) begin
      checks++;
      if (key_valid && frame_err) begin
        $display("[TB] FAIL pulse_exclusive: key_valid=1 frame_err=1 required not both");
      end else if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse: key_valid=%0b frame_err=%0b code=%0h required none",
                 key_valid, frame_err, key_code);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != frame_err || (!e.is_err && e.code != key_code))
          $display("[TB] FAIL event: got err=%0b code=%0h expected err=%0b code=%0h",
                   frame_err, key_code, e.is_err, e.code);
        else passes++;
      end
    end
  end

  initial begin
    logic [7:0] pool [11];
    logic [7:0] b;
    pool = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76, 8'hF0, 8'hE0};

    wait_clks(5);
    check_eq("reset_key_code", key_code, 4'd0);
    check_eq("reset_key_valid", {3'b0, key_valid}, 4'd0);
    check_eq("reset_frame_err", {3'b0, frame_err}, 4'd0);
    rst = 1'b0;
    wait_clks(5);

    send_frame(8'h1C, 0, 0);
    check_eq("make_A", key_code, 4'd1);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check_eq("break_A", key_code, 4'd0);

    send_frame(8'h1C, 0, 0);
    send_frame(8'h1B, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check_eq("break_other_held", key_code, 4'd2);

    send_frame(8'h1D, 1, 0);
    check_eq("parity_err_hold", key_code, 4'd2);
    send_frame(8'h1D, 0, 1);
    check_eq("stop_err_hold", key_code, 4'd2);

    push_event(1'b1, 4'd0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_clks(TIMEOUT + 40);
    send_frame(8'h76, 0, 0);
    check_eq("after_timeout_esc", key_code, 4'd9);

    push_event(1'b1, 4'd0);
    send_bit(1'b1);
    wait_clks(3 * HALF);

    for (int i = 0; i < 3; i++) send_frame(8'h23, 0, 0);
    check_eq("typematic_D", key_code, 4'd4);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check_eq("extended_ignored", key_code, 4'd4);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    ref_key = 4'd0;
    ref_ext = 0;
    ref_brk = 0;
    exp_q.delete();
    wait_clks(2 * TIMEOUT);
    check_eq("midframe_reset_key", key_code, 4'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 10)];
      send_frame(b, $urandom_range(0, 9) == 0, 0);
    end

    wait_clks(50);
    check_eq("queue_drained", 4'(exp_q.size()), 4'd0);
    check_eq("final_key_code", key_code, ref_key);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
